// File: rtl/memory_access_pkg.sv
// Shared M-stage types: access size, dbus request/response, FSM states, strobe constants.
// MEM_MISALIGN_CHECK_EN enables the misaligned-address helper's use in memory_access.
package memory_access_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [2:0] {
    READY,
    ADDR,
    DATA,
    DONE,
    DRAIN
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        sgn;
    msize_t      size;
  } mreg_t;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic logic is_misaligned(msize_t size, logic [1:0] a);
    return ((size == MSIZE2) && a[0]) || ((size == MSIZE4) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Single-outstanding data bus between the M stage (master) and the memory system (slave).
interface memory_access_if;
  import memory_access_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_access_strobe_gen.sv
// Byte-lane strobe and store-data replication for a dbus write of the given size/offset.
module dbus_strobe_gen
  import memory_access_pkg::*;
(
  input  msize_t      size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] data_o
);

  always_comb begin
    strobe_o = '0;
    data_o   = wdata_i;
    case (size_i)
      MSIZE1: begin
        strobe_o = STRB_BYTE << addr_i;
        data_o   = {4{wdata_i[7:0]}};
      end
      MSIZE2: begin
        strobe_o = STRB_HALF << {addr_i[1], 1'b0};
        data_o   = {2{wdata_i[15:0]}};
      end
      MSIZE4: strobe_o = STRB_WORD;
      default: strobe_o = '0;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// M stage: E->M pipeline register, single-outstanding dbus access FSM and response buffer.
// Define MEM_MISALIGN_CHECK_EN to suppress misaligned requests and raise AdEM instead.
module memory_access
  import memory_access_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               StallM,
  input  logic               FlushM,
  input  logic [31:0]        PCE,
  input  logic [31:0]        ALUOutE,
  input  logic [31:0]        WriteDataE,
  input  logic [4:0]         WriteRegE,
  input  logic               RegWriteE,
  input  logic               MemtoRegE,
  input  logic               MemWriteE,
  input  logic               SignedE,
  input  msize_t             SizeE,
  memory_access_if.master    dbus,
  output dbus_resp_t         drespM,
  output logic               MemStall,
  output logic [31:0]        PCM,
  output logic [31:0]        ALUOutM,
  output logic [4:0]         WriteRegM,
  output logic               RegWriteM,
  output logic               MemtoRegM,
  output msize_t             SizeM,
  output logic               SignedM
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic               AdEM
`endif
);

  mem_state_t state_q, state_d;
  mreg_t      m_q, m_d;
  dbus_resp_t resp_q, resp_d;
  logic       m_load, memop, memop_nx, resp_live;
  mem_state_t mem_target, done_next;
  logic [3:0]  gen_strobe;
  logic [31:0] gen_data;

  assign m_load = FlushM | ~StallM;
  assign memop  = m_q.memtoreg | m_q.memwrite;

  always_comb begin
    m_d = m_q;
    if (FlushM) begin
      m_d    = '0;
      m_d.pc = RESET_PC;
    end else if (!StallM) begin
      m_d.pc       = PCE;
      m_d.alu      = ALUOutE;
      m_d.wdata    = WriteDataE;
      m_d.wreg     = WriteRegE;
      m_d.regwrite = RegWriteE;
      m_d.memtoreg = MemtoRegE;
      m_d.memwrite = MemWriteE;
      m_d.sgn      = SignedE;
      m_d.size     = SizeE;
    end
  end

  assign memop_nx = m_d.memtoreg | m_d.memwrite;

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_nx, adem_q;
  assign mis_nx     = memop_nx & is_misaligned(m_d.size, m_d.alu[1:0]);
  assign mem_target = mis_nx ? DONE : ADDR;
  assign AdEM       = adem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     adem_q <= 1'b0;
    else if (m_load) adem_q <= mis_nx;
  end
`else
  assign mem_target = ADDR;
`endif

  // Completing an access on the same edge that loads M hands straight over to the new instruction.
  assign done_next = m_load ? (memop_nx ? mem_target : READY) : DONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= READY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY, DONE: if (m_load) state_d = memop_nx ? mem_target : READY;
      ADDR: begin
        if (dbus.dresp.addr_ok && dbus.dresp.data_ok) state_d = done_next;
        else if (dbus.dresp.addr_ok)                  state_d = FlushM ? DRAIN : DATA;
        else if (FlushM)                              state_d = READY;
      end
      DATA: begin
        if (dbus.dresp.data_ok) state_d = done_next;
        else if (FlushM)        state_d = DRAIN;
      end
      DRAIN: if (dbus.dresp.data_ok) state_d = memop_nx ? mem_target : READY;
      default: state_d = READY;
    endcase
  end

  dbus_strobe_gen u_strobe_gen (
    .size_i   (m_q.size),
    .addr_i   (m_q.alu[1:0]),
    .wdata_i  (m_q.wdata),
    .strobe_o (gen_strobe),
    .data_o   (gen_data)
  );

  always_comb begin
    resp_live = ((state_q == ADDR) && dbus.dresp.addr_ok && dbus.dresp.data_ok)
             || ((state_q == DATA) && dbus.dresp.data_ok);

    dbus.dreq        = '0;
    dbus.dreq.valid  = (state_q == ADDR);
    dbus.dreq.addr   = m_q.alu;
    dbus.dreq.size   = m_q.size;
    dbus.dreq.strobe = m_q.memwrite ? gen_strobe : '0;
    dbus.dreq.data   = gen_data;

    MemStall = ((state_q == ADDR) && !(dbus.dresp.addr_ok && dbus.dresp.data_ok))
            || ((state_q == DATA) && !dbus.dresp.data_ok)
            || ((state_q == DRAIN) && memop);

    drespM = '0;
    if (resp_live)              drespM = dbus.dresp;
    else if (state_q == DONE)   drespM = resp_q;
  end

  always_comb begin
    resp_d = resp_q;
    if (resp_live)   resp_d = dbus.dresp;
    else if (m_load) resp_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q    <= '0;
      m_q.pc <= RESET_PC;
      resp_q <= '0;
    end else begin
      m_q    <= m_d;
      resp_q <= resp_d;
    end
  end

  assign PCM       = m_q.pc;
  assign ALUOutM   = m_q.alu;
  assign WriteRegM = m_q.wreg;
  assign RegWriteM = m_q.regwrite;
  assign MemtoRegM = m_q.memtoreg;
  assign SizeM     = m_q.size;
  assign SignedM   = m_q.sgn;

endmodule
